// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: default widths, reset PC and fetch FSM state encoding.
package fetch_pkg;

   localparam int DEF_PC_W     = 6;
   localparam int DEF_INST_W   = 32;
   localparam int DEF_RESET_PC = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry fetch->decode output register with valid/ready handoff and a flush that drops the entry.
module fetch_out_reg
   import fetch_pkg::*;
#(
   parameter int PC_W   = DEF_PC_W,
   parameter int INST_W = DEF_INST_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [INST_W-1:0] load_inst,
   input  logic [PC_W-1:0]   load_pc,
   input  logic              flush,
   input  logic              ready,
   output logic              valid,
   output logic [INST_W-1:0] inst,
   output logic [PC_W-1:0]   pc
);

   // Handshake: an entry moves to decode on a cycle with valid && ready and no flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         inst  <= '0;
         pc    <= '0;
      end else begin
         if (flush)
            valid <= 1'b0;
         else if (load)
            valid <= 1'b1;
         else if (valid && ready)
            valid <= 1'b0;

         if (load && !flush) begin
            inst <= load_inst;
            pc   <= load_pc;
         end
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: PC, single-outstanding imem requests, redirect/halt handling.
// Optional perf counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int PC_W     = DEF_PC_W,
   parameter int INST_W   = DEF_INST_W,
   parameter int RESET_PC = DEF_RESET_PC
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   input  logic              halt,
   output logic              fd_valid,
   output logic [INST_W-1:0] fd_inst,
   output logic [PC_W-1:0]   fd_pc,
   input  logic              fd_ready,
`ifdef FETCH_CTRL_PERF_EN
   output logic [15:0]       perf_fetched,
   output logic [15:0]       perf_flushed,
`endif
   output logic              busy
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_REQ  = REQ;
   localparam logic [1:0] ST_WAIT = WAIT;
   localparam logic [1:0] ST_HOLD = HOLD;

   logic [1:0]      state, state_d, resume;
   logic [PC_W-1:0] pc, pc_d, req_pc, req_pc_d;
   logic            discard, discard_d, load;

   assign resume = halt ? ST_IDLE : ST_REQ;

   always_comb begin
      state_d   = state;
      pc_d      = pc;
      req_pc_d  = req_pc;
      discard_d = discard;
      load      = 1'b0;
      case (state)
         ST_IDLE: state_d = resume;
         ST_REQ: begin
            if (imem_gnt) begin
               req_pc_d = pc;
               pc_d     = pc + 1'b1;
               state_d  = ST_WAIT;
               // A grant alongside a redirect fetches the stale PC; its data must be dropped.
               if (redirect_valid)
                  discard_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               if (redirect_valid || discard) begin
                  discard_d = 1'b0;
                  state_d   = resume;
               end else begin
                  load    = 1'b1;
                  state_d = ST_HOLD;
               end
            end else if (redirect_valid) begin
               discard_d = 1'b1;
            end
         end
         default: begin
            if (redirect_valid || (fd_valid && fd_ready))
               state_d = resume;
         end
      endcase
      if (redirect_valid)
         pc_d = redirect_pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         pc      <= PC_W'(RESET_PC);
         req_pc  <= '0;
         discard <= 1'b0;
      end else begin
         state   <= state_d;
         pc      <= pc_d;
         req_pc  <= req_pc_d;
         discard <= discard_d;
      end
   end

   fetch_out_reg #(.PC_W(PC_W), .INST_W(INST_W)) u_out (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_inst (imem_rdata),
      .load_pc   (req_pc),
      .flush     (redirect_valid),
      .ready     (fd_ready),
      .valid     (fd_valid),
      .inst      (fd_inst),
      .pc        (fd_pc)
   );

   assign imem_req  = (state == ST_REQ);
   assign imem_addr = pc;
   assign busy      = (state != ST_IDLE) || fd_valid;

`ifdef FETCH_CTRL_PERF_EN
   logic fetched_ev, flushed_ev;

   assign fetched_ev = fd_valid && fd_ready && !redirect_valid;
   assign flushed_ev = (state == ST_WAIT && imem_rvalid && (discard || redirect_valid))
                    || (redirect_valid && fd_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
      end else begin
         if (fetched_ev && perf_fetched != 16'hFFFF)
            perf_fetched <= perf_fetched + 16'd1;
         if (flushed_ev && perf_flushed != 16'hFFFF)
            perf_flushed <= perf_flushed + 16'd1;
      end
   end
`endif

   always @(posedge clk) begin
      if (rst_n)
         assert (!imem_rvalid || state == ST_WAIT);
   end

endmodule
